lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
Load/store unit sitting directly downstream of the execute ALU. It takes the ALU result as the effective address, plus the rs2 store data, destination register and opcode. It then runs a single-outstanding request/acknowledge transaction on the data-memory port. For loads it returns aligned, sign- or zero-extended data to writeback. Opcodes use the shared 6-bit instruction enum: i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw.

Parameters:
WIDTH, 32, data and address width; only 32 is supported.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  execute result valid
in_ready  output  1  unit can accept an op; high only in IDLE
instr  input  6  opcode from the instruction enum
addr  input  WIDTH  effective address (ALU output)
store_data  input  WIDTH  rs2 value for stores
rd_in  input  5  destination register
mem_req  output  1  memory request; held until ack
mem_we  output  1  1 = store
mem_addr  output  WIDTH  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  WIDTH  lane-replicated store data
mem_wstrb  output  4  byte write strobes; 0 for loads
mem_ack  input  1  memory completion
mem_rdata  input  WIDTH  read word, valid when mem_ack=1
out_valid  output  1  result valid to writeback
out_ready  input  1  writeback accepts result
out_data  output  WIDTH  formatted load data; 0 for stores and exceptions
out_rd  output  5  destination register
out_we  output  1  register write enable
misaligned  output  1  misalignment exception flag, qualified by out_valid
exc_addr  output  WIDTH  faulting address, qualified by misaligned

Behaviour:
- Reset (async): state IDLE; mem_req, mem_we, mem_wstrb, out_valid, out_we, misaligned = 0; mem_addr, mem_wdata, out_data, exc_addr, out_rd = 0.
- States: IDLE, REQ, RESP.
- IDLE
  - in_ready=1.
  - On in_valid, register instr, addr, store_data, rd_in.
  - Aligned memory op -> REQ.
  - Misaligned op -> RESP with misaligned=1, exc_addr=addr, out_we=0, out_data=0. No memory request is issued.
  - Non-memory opcode -> RESP as a no-op: out_we=0, misaligned=0.
- Alignment rules:
  - lh/lhu/sh are misaligned when addr[0]=1.
  - lw/sw are misaligned when addr[1:0]!=0.
  - Byte ops are never misaligned.
- REQ
  - mem_req=1; mem_addr, mem_we, mem_wdata, mem_wstrb stable until mem_ack is sampled high.
  - mem_ack may arrive in the first REQ cycle.
  - On ack: load data is formatted and registered into out_data; mem_req drops next cycle; -> RESP.
- RESP
  - out_valid=1; all out_* held stable while out_ready=0.
  - On out_ready=1 -> IDLE; out_valid drops next cycle.
- Latency and throughput:
  - Minimum latency: accept at cycle T, mem_req at T+1 (ack T+1), out_valid at T+2.
  - One op in flight; no overlap between accept and response.
- Load formatting, with off = addr[1:0]:
  - lb: sign-extend rdata[8*off+7:8*off].
  - lbu: zero-extend the same byte.
  - lh / lhu: sign- / zero-extend rdata[16*addr[1]+15:16*addr[1]].
  - lw: full word.
- Store formatting:
  - sb: wdata={4{sd[7:0]}}, wstrb=4'b0001<<off.
  - sh: wdata={2{sd[15:0]}}, wstrb=4'b0011<<(2*addr[1]).
  - sw: wdata=sd, wstrb=4'b1111.
  - Stores complete with out_valid=1, out_we=0, out_data=0.
- out_we = 1 only for a successful load with rd != 0.
- Boundary conditions:
  - mem_ack outside REQ is ignored.
  - in_valid outside IDLE is ignored; the producer must hold its data.
  - rst mid-REQ deasserts mem_req immediately (async); a late ack after reset is ignored.
  - rst during RESP drops out_valid immediately.

Test Plan:
1. lw addr=0x100, ack one cycle after req with rdata=0xDEADBEEF, rd=5 -> mem_addr=0x100, wstrb=0, out_data=0xDEADBEEF, out_we=1, out_rd=5; out_valid two cycles after accept.
2. lb addr=0x203, rdata=0x80123456 -> out_data=0xFFFFFF80; same with lbu -> 0x00000080; lhu addr=0x202 -> 0x00008012.
3. sh addr=0x306, store_data=0x1234ABCD -> mem_addr=0x304, wdata=0xABCDABCD, wstrb=4'b1100, mem_we=1; out_valid with out_we=0.
4. lw addr=0x102 -> mem_req never asserted; out_valid with misaligned=1, exc_addr=0x102, out_we=0; sb at 0x103 succeeds.
5. Ack delayed 4 cycles and out_ready held low 3 cycles -> mem_req and its fields stable for all 5 REQ cycles; out_* stable in RESP; in_ready=0 until the cycle after the out_valid/out_ready handshake.
6. rst pulsed during REQ then a stray mem_ack -> mem_req=0 asynchronously, state IDLE, no out_valid, in_ready=1; lw rd=0 afterwards -> out_valid with out_we=0.

Source files
------------

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - load/store unit: one outstanding req/ack memory transaction, load formatting
package lsu_pkg;
  typedef enum logic [5:0] {
    i_nop = 6'h00,
    i_lb  = 6'h10,
    i_lh  = 6'h11,
    i_lw  = 6'h12,
    i_lbu = 6'h13,
    i_lhu = 6'h14,
    i_sb  = 6'h15,
    i_sh  = 6'h16,
    i_sw  = 6'h17
  } instr_e;
endpackage

module lsu_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       instr,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  input  logic [4:0]       rd_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             misaligned,
  output logic [WIDTH-1:0] exc_addr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e           state_q;
  logic [5:0]       instr_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic             mem_req_q, mem_we_q, out_valid_q, out_we_q, misaligned_q;
  logic [3:0]       mem_wstrb_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q, out_data_q, exc_addr_q;
  logic [4:0]       out_rd_q;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      i_lb, i_lh, i_lw, i_lbu, i_lhu: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      i_sb, i_sh, i_sw: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      i_lh, i_lhu, i_sh: return off[0];
      i_lw, i_sw:        return off != 2'b00;
      default:           return 1'b0;
    endcase
  endfunction

  // Stores replicate the data across every lane; the strobes pick the lanes written.
  function automatic logic [WIDTH-1:0] store_wdata(input logic [5:0] op, input logic [WIDTH-1:0] sd);
    case (op)
      i_sb:    return {4{sd[7:0]}};
      i_sh:    return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [5:0] op, input logic [1:0] off);
    case (op)
      i_sb:    return 4'b0001 << off;
      i_sh:    return 4'b0011 << {off[1], 1'b0};
      i_sw:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] load_fmt(input logic [5:0] op, input logic [1:0] off,
                                                input logic [WIDTH-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (op)
      i_lb:    return {{24{b[7]}}, b};
      i_lbu:   return {24'h0, b};
      i_lh:    return {{16{h[15]}}, h};
      i_lhu:   return {16'h0, h};
      i_lw:    return rdata;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_we_q     <= 1'b0;
      misaligned_q <= 1'b0;
      out_data_q   <= '0;
      out_rd_q     <= '0;
      exc_addr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            instr_q  <= instr;
            off_q    <= addr[1:0];
            rd_q     <= rd_in;
            out_rd_q <= rd_in;
            if (!is_load(instr) && !is_store(instr)) begin
              out_valid_q  <= 1'b1;
              out_we_q     <= 1'b0;
              misaligned_q <= 1'b0;
              out_data_q   <= '0;
              state_q      <= S_RESP;
            end else if (is_misaligned(instr, addr[1:0])) begin
              out_valid_q  <= 1'b1;
              out_we_q     <= 1'b0;
              misaligned_q <= 1'b1;
              exc_addr_q   <= addr;
              out_data_q   <= '0;
              state_q      <= S_RESP;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store(instr);
              mem_addr_q  <= {addr[WIDTH-1:2], 2'b00};
              mem_wdata_q <= store_wdata(instr, store_data);
              mem_wstrb_q <= store_wstrb(instr, addr[1:0]);
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            misaligned_q <= 1'b0;
            out_data_q   <= load_fmt(instr_q, off_q, mem_rdata);
            out_we_q     <= is_load(instr_q) && (rd_q != 5'd0);
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            out_we_q     <= 1'b0;
            misaligned_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_rd     = out_rd_q;
  assign out_we     = out_we_q;
  assign misaligned = misaligned_q;
  assign exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - scoreboard bench for lsu_stage
module tb_lsu_stage;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  instr = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we, misaligned;
  logic [31:0] exc_addr;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic [31:0] exc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  lsu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .addr(addr), .store_data(store_data), .rd_in(rd_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_we(out_we), .misaligned(misaligned),
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; instr = op; addr = a; store_data = sd; rd_in = rd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; instr = $urandom; addr = $urandom; store_data = $urandom; rd_in = $urandom;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int ack_dly, input int rdy_dly);
    exp_t e, got;
    logic ld, st, mis;
    logic [1:0] off;
    logic [31:0] b, h, ewd;
    logic [3:0] ews;
    off = a[1:0];
    ld  = (op == i_lb) || (op == i_lh) || (op == i_lw) || (op == i_lbu) || (op == i_lhu);
    st  = (op == i_sb) || (op == i_sh) || (op == i_sw);
    mis = ((op == i_lh || op == i_lhu || op == i_sh) && a[0]) ||
          ((op == i_lw || op == i_sw) && off != 2'b00);
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * a[1])) & 32'hFFFF;
    e.data = 32'h0;
    if (ld && !mis) begin
      if (op == i_lb)  e.data = b[7] ? (b | 32'hFFFFFF00) : b;
      if (op == i_lbu) e.data = b;
      if (op == i_lh)  e.data = h[15] ? (h | 32'hFFFF0000) : h;
      if (op == i_lhu) e.data = h;
      if (op == i_lw)  e.data = rdata;
    end
    e.rd  = rd;
    e.we  = ld && !mis && (rd != 5'd0);
    e.mis = mis;
    e.exc = a;
    ewd = (op == i_sb) ? sd[7:0] * 32'h01010101 : (op == i_sh) ? sd[15:0] * 32'h00010001 : sd;
    ews = (op == i_sb) ? 4'(1 << off) : (op == i_sh) ? 4'(3 << (2 * a[1])) :
          (op == i_sw) ? 4'hF : 4'h0;
    exp_q.push_back(e);

    accept(op, a, sd, rd);
    if ((ld || st) && !mis) begin
      for (int c = 0; c <= ack_dly; c++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_we", mem_we, st);
        chk("mem_wstrb", mem_wstrb, ews);
        if (st) chk("mem_wdata", mem_wdata, ewd);
        chk("out_valid_in_req", out_valid, 0);
        chk("in_ready_in_req", in_ready, 0);
        if (c == ack_dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clk);
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    chk("mem_req_in_resp", mem_req, 0);
    for (int c = 0; c <= rdy_dly; c++) begin
      chk("out_valid", out_valid, 1);
      chk("in_ready_in_resp", in_ready, 0);
      if (c < rdy_dly) begin
        chk("hold_out_data", out_data, exp_q[0].data);
        chk("hold_out_we", out_we, exp_q[0].we);
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
        got = exp_q.pop_front();
        chk("out_data", out_data, got.data);
        chk("out_rd", out_rd, got.rd);
        chk("out_we", out_we, got.we);
        chk("misaligned", misaligned, got.mis);
        if (got.mis) chk("exc_addr", exc_addr, got.exc);
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_misaligned", misaligned, 0);
    rst = 1'b0;

    // stray ack while idle
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    chk("idle_ack_out_valid", out_valid, 0);
    chk("idle_ack_mem_req", mem_req, 0);

    run_op(i_lw,  32'h100, 32'h0,        5'd5,  32'hDEADBEEF, 0, 0);
    run_op(i_lb,  32'h203, 32'h0,        5'd6,  32'h80123456, 0, 0);
    run_op(i_lbu, 32'h203, 32'h0,        5'd6,  32'h80123456, 1, 0);
    run_op(i_lhu, 32'h202, 32'h0,        5'd7,  32'h80123456, 0, 1);
    run_op(i_lh,  32'h202, 32'h0,        5'd8,  32'h80123456, 0, 0);
    run_op(i_lb,  32'h200, 32'h0,        5'd9,  32'h0000007F, 0, 0);
    run_op(i_sh,  32'h306, 32'h1234ABCD, 5'd3,  32'h0,        0, 0);
    run_op(i_sb,  32'h103, 32'h000000A5, 5'd4,  32'h0,        0, 0);
    run_op(i_sw,  32'h308, 32'hCAFEF00D, 5'd0,  32'h0,        0, 0);
    run_op(i_lw,  32'h102, 32'h0,        5'd5,  32'h0,        0, 0);
    run_op(i_lh,  32'h101, 32'h0,        5'd5,  32'h0,        0, 0);
    run_op(i_sw,  32'h30A, 32'h11111111, 5'd2,  32'h0,        0, 0);
    run_op(i_nop, 32'h0,   32'h0,        5'd1,  32'h0,        0, 0);
    run_op(i_lw,  32'h400, 32'h13579BDF, 5'd10, 32'h13579BDF, 4, 3);
    for (int i = 0; i < 8; i++)
      run_op(i_lbu, 32'h500 + i, 32'h0, 5'(i + 1), $urandom, $urandom_range(0, 2),
             $urandom_range(0, 2));

    // reset in the middle of a request, then a late ack
    accept(i_lw, 32'h600, 32'h0, 5'd7);
    chk("req_before_rst", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); mem_ack = 1'b0;
    chk("late_ack_out_valid", out_valid, 0);
    chk("late_ack_mem_req", mem_req, 0);
    chk("late_ack_in_ready", in_ready, 1);
    run_op(i_lw, 32'h604, 32'h0, 5'd0, 32'h89ABCDEF, 0, 0);

    // reset while a response is pending
    accept(i_nop, 32'h0, 32'h0, 5'd3);
    chk("resp_before_rst", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    run_op(i_lh, 32'h702, 32'h0, 5'd12, 32'h7FFF0000, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
